// File: rtl/serdes_pkg.sv
// Shared types and frame constants for the SerDes TX scheduler and its arbiter.
package serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ID,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  function automatic int calc_id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int calc_frame_len(input int n_req, input int data_w);
    return 2 + calc_id_w(n_req) + data_w;
  endfunction

  localparam int FRAME_LEN_DEFAULT = calc_frame_len(4, 8);

endpackage

// File: rtl/serdes_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module serdes_rr_arbiter
  import serdes_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = calc_id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  // N_REQ is a power of two, so ID_W-bit addition wraps modulo N_REQ for free.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && req_valid[ID_W'(rr_ptr + ID_W'(i))]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(rr_ptr + ID_W'(i));
      end
    end
    grant[grant_idx] = grant_any;
  end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Round-robin byte scheduler that frames each accepted byte (start, ID, data, stop)
// and shifts it onto the single serial lane, one bit per enabled clock.
module serdes_tx_scheduler
  import serdes_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int ID_W   = calc_id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    ser_out,
  output logic                    ser_busy,
  output logic [ID_W-1:0]         cur_id,
  output logic                    frame_done
);

  // Handshake: a byte transfers in the cycle where req_valid[k] and req_ready[k]
  // are both high; the requester holds valid/data stable until then.

  localparam int SR_W  = ID_W + DATA_W;
  localparam int CNT_MAX = (DATA_W > ID_W) ? DATA_W : ID_W;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_busy_q, ser_busy_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              frame_done_q, frame_done_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              arb_phase;
  logic [DATA_W-1:0] sel_data;

  serdes_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == ID_W'(k)) sel_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  // rst_n gates the grant so no accept pulse escapes while reset is held.
  assign arb_phase  = ena && rst_n && ((state_q == ST_IDLE) || (state_q == ST_STOP));
  assign req_ready  = arb_phase ? grant : '0;
  assign ser_out    = ser_out_q;
  assign ser_busy   = ser_busy_q;
  assign cur_id     = cur_id_q;
  assign frame_done = frame_done_q & ena;

  // ser_out_q always carries the bit belonging to the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    rr_ptr_d     = rr_ptr_q;
    ser_out_d    = ser_out_q;
    ser_busy_d   = ser_busy_q;
    cur_id_d     = cur_id_q;
    frame_done_d = frame_done_q;
    if (ena) begin
      frame_done_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_STOP: begin
          cnt_d = '0;
          if (arb_phase && grant_any) begin
            state_d    = ST_START;
            sr_d       = {sel_data, grant_idx};
            rr_ptr_d   = grant_idx + ID_W'(1);
            ser_out_d  = START_BIT;
            ser_busy_d = 1'b1;
            cur_id_d   = grant_idx;
          end else begin
            state_d    = ST_IDLE;
            ser_out_d  = IDLE_LEVEL;
            ser_busy_d = 1'b0;
          end
        end
        ST_START: begin
          state_d   = ST_ID;
          cnt_d     = '0;
          ser_out_d = sr_q[0];
          sr_d      = sr_q >> 1;
        end
        ST_ID: begin
          ser_out_d = sr_q[0];
          sr_d      = sr_q >> 1;
          if (cnt_q == CNT_W'(ID_W - 1)) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d      = ST_STOP;
            cnt_d        = '0;
            ser_out_d    = STOP_BIT;
            frame_done_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            ser_out_d = sr_q[0];
            sr_d      = sr_q >> 1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          ser_out_d  = IDLE_LEVEL;
          ser_busy_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      rr_ptr_q     <= '0;
      ser_out_q    <= IDLE_LEVEL;
      ser_busy_q   <= 1'b0;
      cur_id_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      rr_ptr_q     <= rr_ptr_d;
      ser_out_q    <= ser_out_d;
      ser_busy_q   <= ser_busy_d;
      cur_id_q     <= cur_id_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Directed bench for serdes_tx_scheduler: table of single frames plus
// multi-frame sequences for round-robin order, back-to-back, enable stalls and reset.
module tb_serdes_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        ser_out;
  logic        ser_busy;
  logic [1:0]  cur_id;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [7:0]  data;
    logic [3:0]  exp_ready;
    logic [11:0] exp_bits;   // bit 11 is the first bit on the lane
  } vec_t;

  vec_t        vecs[6];
  logic [11:0] four_bits[4];

  serdes_tx_scheduler #(.N_REQ(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ser_out    (ser_out),
    .ser_busy   (ser_busy),
    .cur_id     (cur_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] d);
    req_valid[k]      = 1'b1;
    req_data[k*8 +: 8] = d;
  endtask

  // Entered just after the grant edge; returns at the negedge of the stop-bit cycle.
  task automatic check_frame(input int id, input logic [11:0] bits, input logic [3:0] next_mask,
                             input int stall_k, input int stall_len);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("ser_out", ser_out, bits[11-k]);
      chk("ser_busy", ser_busy, 1'b1);
      chk("frame_done", frame_done, (k == 11));
      chk("cur_id", cur_id, id);
      chk("req_ready", req_ready, (k == 11) ? next_mask : 4'b0000);
      if (k == stall_k) begin
        ena = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_ser_out", ser_out, bits[11-k]);
          chk("stall_busy", ser_busy, 1'b1);
          chk("stall_frame_done", frame_done, 1'b0);
          chk("stall_req_ready", req_ready, 4'b0000);
        end
        ena = 1'b1;
      end
    end
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_ser_out", ser_out, 1'b0);
    chk("idle_busy", ser_busy, 1'b0);
    chk("idle_frame_done", frame_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, 8'hAA, 4'b0100, 12'b1010_1010_1010};
    vecs[1] = '{0, 8'h00, 4'b0001, 12'b1000_0000_0000};
    vecs[2] = '{3, 8'hFF, 4'b1000, 12'b1111_1111_1110};
    vecs[3] = '{1, 8'h01, 4'b0010, 12'b1101_0000_0000};
    vecs[4] = '{1, 8'hCC, 4'b0010, 12'b1100_0110_0110};
    vecs[5] = '{2, 8'h55, 4'b0100, 12'b1011_0101_0100};
    four_bits[0] = 12'b1001_0001_0000;  // req0 0x11
    four_bits[1] = 12'b1100_1000_1000;  // req1 0x22
    four_bits[2] = 12'b1011_1001_1000;  // req2 0x33
    four_bits[3] = 12'b1110_0100_0100;  // req3 0x44

    rst_n = 1'b0; ena = 1'b1; req_valid = 4'hF; req_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_busy", ser_busy, 1'b0);
    chk("rst_cur_id", cur_id, 2'd0);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_frame_done", frame_done, 1'b0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester frames
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      set_req(vecs[v].id, vecs[v].data);
      @(negedge clk);
      chk("grant", req_ready, vecs[v].exp_ready);
      @(posedge clk); #1;
      req_valid = 4'h0;
      check_frame(vecs[v].id, vecs[v].exp_bits, 4'b0000, -1, 0);
      check_idle();
    end

    // All four valid from reset: grants 0,1,2,3 with no idle bits
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 8'h11); set_req(1, 8'h22); set_req(2, 8'h33); set_req(3, 8'h44);
    @(negedge clk);
    chk("all4_grant0", req_ready, 4'b0001);
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      check_frame(g, four_bits[g], (g < 3) ? 4'(1 << (g + 1)) : 4'b0000, -1, 0);
    end
    check_idle();

    // Fairness wrap: after req3, pointer wraps so req0 beats req3
    @(posedge clk); #1;
    set_req(3, 8'hFF);
    @(negedge clk);
    chk("wrap_grant3", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = 4'h0;
    set_req(0, 8'h00); set_req(3, 8'h01);
    check_frame(3, 12'b1111_1111_1110, 4'b0001, -1, 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check_frame(0, 12'b1000_0000_0000, 4'b1000, -1, 0);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    check_frame(3, 12'b1111_0000_0000, 4'b0000, -1, 0);
    check_idle();

    // Back-to-back from req1: 0xCC then 0x55
    @(posedge clk); #1;
    set_req(1, 8'hCC);
    @(negedge clk);
    chk("b2b_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_data[15:8] = 8'h55;
    check_frame(1, 12'b1100_0110_0110, 4'b0010, -1, 0);
    @(posedge clk); #1;
    req_valid = 4'h0;
    check_frame(1, 12'b1101_0101_0100, 4'b0000, -1, 0);
    check_idle();

    // Enable stalls: 3 cycles on DATA bit 4, then 2 cycles on the stop bit
    @(posedge clk); #1;
    set_req(1, 8'hCC);
    @(negedge clk);
    chk("ena_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'h0;
    set_req(2, 8'h55);
    check_frame(1, 12'b1100_0110_0110, 4'b0100, 7, 3);
    @(posedge clk); #1;
    req_valid = 4'h0;
    check_frame(2, 12'b1011_0101_0100, 4'b0000, 11, 2);
    check_idle();

    // Asynchronous reset mid-DATA, then fresh frames with pointer back at 0
    @(posedge clk); #1;
    set_req(1, 8'hCC);
    @(negedge clk);
    chk("rst_test_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'h0;
    set_req(3, 8'hFF);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ser_out", ser_out, 1'b0);
    chk("async_rst_busy", ser_busy, 1'b0);
    chk("async_rst_req_ready", req_ready, 4'b0000);
    chk("async_rst_frame_done", frame_done, 1'b0);
    chk("async_rst_cur_id", cur_id, 2'd0);
    repeat (2) @(negedge clk);
    set_req(1, 8'h01);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check_frame(1, 12'b1101_0000_0000, 4'b1000, -1, 0);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    check_frame(3, 12'b1111_1111_1110, 4'b0000, -1, 0);
    check_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serdes_tx_scheduler.md
# serdes_tx_scheduler

Round-robin scheduler that shares the single serial lane of the SerDes link between `N_REQ` byte requesters. It accepts one byte per valid/ready handshake, wraps it in a fixed frame (start bit, requester ID, data LSB first, stop bit), and drives it bit-serially, one bit per clock, onto the lane the deserializer samples. It sits in front of the serializer lane inside the top-level SerDes tile.

## Interface
- `N_REQ`, default 4: number of requesters; power of two, 2..8.
- `DATA_W`, default 8: payload bits per frame.
- `clk`  in  1: single clock; all logic rises on `posedge clk`.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: global enable; low freezes all state.
- `req_valid`  in  `N_REQ`: per-requester byte valid; held until ready.
- `req_data`  in  `N_REQ*DATA_W`: requester k's byte is at bits [k*DATA_W +: DATA_W].
- `req_ready`  out  `N_REQ`: one-hot, one-cycle accept pulse.
- `ser_out`  out  1: serial lane, registered; idles low.
- `ser_busy`  out  1: high while a frame is on the lane.
- `cur_id`  out  `ID_W`: ID of the frame in flight; `ID_W = clog2(N_REQ)`.
- `frame_done`  out  1: one-cycle pulse on the stop-bit cycle.

## Operation
- Frame is `FRAME_LEN = 2 + ID_W + DATA_W` bits (12 at defaults): start=1, ID LSB first, data LSB first, stop=0.
- FSM states: IDLE, START, ID, DATA, STOP. A bit counter indexes ID and DATA bits.
  - IDLE -> START on grant. START -> ID. ID -> DATA after `ID_W` bits. DATA -> STOP after `DATA_W` bits.
  - STOP -> START on grant, otherwise STOP -> IDLE.
- Arbitration runs only in IDLE or STOP with `ena`=1. If any `req_valid` is set, the first set bit at or after `rr_ptr` (wrapping modulo `N_REQ`) wins.
  - The winner's `req_ready` pulses for that cycle. Its data and ID are latched into the shift register. `rr_ptr` becomes winner+1 mod `N_REQ`.
- `req_ready` is never asserted outside IDLE/STOP, never when `ena`=0, and never for a requester whose `req_valid`=0.
- Valid/ready rule: a requester keeps `req_valid` and `req_data` stable until it sees `req_ready`. Dropping `req_valid` early is legal; that requester is simply not granted.
- `ena`=0: state, counter, shift register, `rr_ptr` and all outputs hold. `frame_done` and `req_ready` are forced 0 while `ena`=0.
- Reset values, applied asynchronously at any time including mid-frame:
  - state=IDLE, `rr_ptr`=0, counter=0.
  - `ser_out`=0, `ser_busy`=0, `cur_id`=0, `req_ready`=0, `frame_done`=0.
  - A partially sent frame is abandoned, not resumed.

## Timing
- Handshake at cycle T (`req_ready`=1) -> start bit on `ser_out` at T+1.
- ID bits at T+2..T+1+ID_W, data bits at T+2+ID_W..T+1+ID_W+DATA_W, stop bit at T+FRAME_LEN.
- `frame_done`=1 during cycle T+FRAME_LEN, the stop-bit cycle.
- Back-to-back: a grant in the stop-bit cycle puts the next start bit at T+FRAME_LEN+1. There are no idle bits between frames, so lane throughput is 1 frame per `FRAME_LEN` cycles.
- `ser_busy` is high from the start bit through the stop bit inclusive. `cur_id` updates on the start-bit cycle and holds through stop.
- Grant decision is combinational from `req_valid` and `rr_ptr`; `req_ready` is a same-cycle output. All other outputs are registered.
- Any `ena`=0 cycles stretch the frame by exactly that many cycles; no bit is skipped or duplicated.

## Structure
- Package `serdes_pkg`:
  - state enum (IDLE, START, ID, DATA, STOP);
  - `START_BIT`=1, `STOP_BIT`=0, `IDLE_LEVEL`=0;
  - `FRAME_LEN` and `ID_W` derived by function from the parameters.
- Sub-module `serdes_rr_arbiter`: combinational one-hot round-robin pick from `req_valid` and `rr_ptr`, returning a grant vector and an encoded index. Reused later for the RX-side response mux.
- Top: FSM, bit counter, `ID_W+DATA_W` shift register, `rr_ptr` register, output registers.

## Test plan
- Single request, req 2, data 0xAA, other requesters idle:
  - `req_ready`=4'b0100 for one cycle;
  - `ser_out` from T+1 = 1,0,1,0,1,0,1,0,1,0,1,0 (start, ID=2 LSB first, 0xAA LSB first, stop);
  - `frame_done` at T+12, then `ser_out`=0 and `ser_busy`=0.
- All four valid from reset (data 0x11,0x22,0x33,0x44):
  - grants in order 0,1,2,3 at T, T+12, T+24, T+36;
  - no idle bit between frames; `cur_id` steps 0..3.
- Fairness wrap: req 3 granted, then reqs 0 and 3 both valid at the next STOP -> req 0 granted, because `rr_ptr` wrapped to 0.
- Back-to-back from one requester (req 1: 0xCC then 0x55):
  - second `req_ready` lands on the first frame's stop-bit cycle;
  - 24 contiguous correct bits on `ser_out`.
- `ena` low for 3 cycles during DATA bit 4 of a 0xCC frame:
  - `ser_out` holds bit 4 for 4 cycles total;
  - remaining bits are correct; `frame_done` is delayed by 3 cycles.
- `rst_n` asserted mid-DATA (async, between clock edges):
  - immediately `ser_out`=0, `ser_busy`=0, `req_ready`=0;
  - after release, a pending req 3 gets a fresh, complete frame and `rr_ptr` restarts at 0.
